// File: rtl/f16_pkg.sv
// Shared f16 definitions: FSM state encoding, field constants and saturation helper.
`default_nettype none

package f16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          BIAS        = 15;
  localparam logic [4:0]  EXP_MAX     = 5'h1F;
  localparam logic [15:0] MAX_FINITE  = 16'h7BFF;
  localparam logic [15:0] SAT_PATTERN = 16'h7FFF;

  function automatic logic [15:0] f16_sat(input logic sign);
    return {sign, SAT_PATTERN[14:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/f16_fmac_normal_no_grs.sv
// Combinational f16 r = x*y + z for normal operands; truncating, no guard/round/sticky bits.
`default_nettype none

module f16_fmac_normal_no_grs
  import f16_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  output logic [15:0] r
);

  logic               sp, sz, s_big, s_small, s_res;
  logic [4:0]         ex, ey, ez, k;
  logic [21:0]        mp;
  logic               p_zero, z_zero;
  logic signed [8:0]  ep, eb, d, nd, e_big, e_res;
  logic [23:0]        m_a, m_b, m_big, m_small, m_sum;
  logic [9:0]         frac;

  always_comb begin
    sp     = x[15] ^ y[15];
    sz     = z[15];
    ex     = x[14:10];
    ey     = y[14:10];
    ez     = z[14:10];
    p_zero = (ex == 5'd0) || (ey == 5'd0);
    z_zero = (ez == 5'd0);

    mp = {11'b0, 1'b1, x[9:0]} * {11'b0, 1'b1, y[9:0]};
    ep = $signed({4'b0, ex}) + $signed({4'b0, ey}) - $signed(9'(BIAS));

    // Both operands share a fixed point at bit 20 of a 24-bit magnitude.
    m_a = {2'b0, mp};
    m_b = z_zero ? 24'd0 : {3'b0, 1'b1, z[9:0], 10'b0};
    eb  = z_zero ? ep : $signed({4'b0, ez});
    d   = ep - eb;
    nd  = eb - ep;

    if (d >= 9'sd0) begin
      e_big   = ep;
      m_big   = m_a;
      s_big   = sp;
      s_small = sz;
      m_small = (d > 9'sd23) ? 24'd0 : (m_b >> d[4:0]);
    end else begin
      e_big   = eb;
      m_big   = m_b;
      s_big   = sz;
      s_small = sp;
      m_small = (nd > 9'sd23) ? 24'd0 : (m_a >> nd[4:0]);
    end

    if (s_big == s_small) begin
      m_sum = m_big + m_small;
      s_res = s_big;
    end else if (m_big >= m_small) begin
      m_sum = m_big - m_small;
      s_res = s_big;
    end else begin
      m_sum = m_small - m_big;
      s_res = s_small;
    end

    k = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (m_sum[i]) k = 5'(i);
    end

    e_res = e_big + $signed({4'b0, k}) - 9'sd20;
    frac  = 10'((m_sum << (5'd23 - k)) >> 13);

    if (p_zero)
      r = {sz, z_zero ? 15'd0 : z[14:0]};
    else if (m_sum == 24'd0)
      r = 16'h0000;
    else if (e_res >= 9'sd31)
      r = f16_sat(s_res);
    else if (e_res <= 9'sd0)
      r = {s_res, 15'd0};
    else
      r = {s_res, e_res[4:0], frac};
  end

endmodule

`default_nettype wire

// File: rtl/f16_dot_seq.sv
// Sequential f16 dot product: accumulates len x*y pairs onto a seed, one pair per cycle.
`default_nettype none

module f16_dot_seq
  import f16_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      z_init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_ovf,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [15:0]      acc, acc_nxt, fmac_r;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             accept;

  f16_fmac_normal_no_grs u_fmac (
    .x (in_x),
    .y (in_y),
    .z (acc),
    .r (fmac_r)
  );

  assign in_ready   = (state == RUN);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_result = acc;
  assign out_ovf    = ovf;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= 16'h0000;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt = z_init;
          ovf_nxt = 1'b0;
          if (len != '0) begin
            cnt_nxt   = len;
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (accept) begin
          acc_nxt = fmac_r;
          cnt_nxt = cnt - 1'b1;
          if (fmac_r[14:10] == EXP_MAX) ovf_nxt = 1'b1;
          if (cnt == LEN_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        // A start coinciding with this handshake is dropped; IDLE must see it.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_f16_dot_seq.sv
// Directed self-checking bench for f16_dot_seq.
`default_nettype none

module tb_f16_dot_seq;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      z_init;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_x;
  logic [15:0]      in_y;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic             out_ovf;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  f16_dot_seq #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .z_init     (z_init),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input logic [LEN_W-1:0] l, input logic [15:0] z);
    start  = 1'b1;
    len    = l;
    z_init = z;
    cyc();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; z_init = 16'h0; in_valid = 1'b0;
    in_x = 16'h0; in_y = 16'h0; out_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/busy/ovf=%b expected 0000", {in_ready, out_valid, busy, out_ovf});
    end
    n_checks++;
    if (out_result !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_result: got %h expected 0000", out_result);
    end
  endtask

  task automatic test_basic();
    begin_job(8'd2, 16'h0000);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_run: got in_ready=%b busy=%b expected 1 1", in_ready, busy);
    end
    in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h4000;
    cyc();
    in_x = 16'h4000; in_y = 16'h4000;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 16'h4000) begin
      n_fail++;
      $display("FAIL basic_step1: got vld=%b acc=%h expected 0 4000", out_valid, out_result);
    end
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h4600 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got vld=%b res=%h ovf=%b expected 1 4600 0", out_valid, out_result, out_ovf);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got busy=%b vld=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_zero_len();
    begin_job(8'd0, 16'h4200);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h4200 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: got vld=%b res=%h rdy=%b expected 1 4200 0", out_valid, out_result, in_ready);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_idle: got busy=%b rdy=%b expected 0 0", busy, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int         accepts;
    pat     = 6'b101001;
    accepts = 0;
    begin_job(8'd3, 16'h0000);
    in_x = 16'h3C00; in_y = 16'h3C00;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      if (in_valid && in_ready) accepts++;
      cyc();
    end
    in_valid = 1'b0;
    n_checks++;
    if (accepts != 3) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d expected 3", accepts);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 16'h4200 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got vld=%b res=%h rdy=%b expected 1 4200 0", i, out_valid, out_result, in_ready);
      end
      cyc();
    end
    out_ready = 1'b1;
    start = 1'b1; len = 8'd1; z_init = 16'h1234;
    cyc();
    out_ready = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got busy=%b vld=%b expected 0 0", busy, out_valid);
    end
    cyc();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_start_on_handshake: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_overflow();
    begin_job(8'd1, 16'h0000);
    in_valid = 1'b1; in_x = 16'h7BFF; in_y = 16'h7BFF;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h7FFF || out_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sat: got vld=%b res=%h ovf=%b expected 1 7fff 1", out_valid, out_result, out_ovf);
    end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    begin_job(8'd1, 16'h0000);
    n_checks++;
    if (out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared_on_start: got %b expected 0", out_ovf);
    end
    in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h3C00;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h3C00 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_next_job: got vld=%b res=%h ovf=%b expected 1 3c00 0", out_valid, out_result, out_ovf);
    end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  task automatic test_cancel();
    begin_job(8'd2, 16'h4000);
    in_valid = 1'b1; in_x = 16'hBC00; in_y = 16'h4000;
    cyc();
    n_checks++;
    if (out_result !== 16'h0000) begin
      n_fail++;
      $display("FAIL cancel_step1: got %h expected 0000", out_result);
    end
    in_x = 16'h0000; in_y = 16'h5000;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h0000 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_result: got vld=%b res=%h ovf=%b expected 1 0000 0", out_valid, out_result, out_ovf);
    end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  task automatic test_stray_start_and_reset();
    begin_job(8'd2, 16'h0000);
    in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h4000;
    cyc();
    in_valid = 1'b0;
    start = 1'b1; len = 8'd5; z_init = 16'h1234;
    cyc();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_result !== 16'h4000) begin
      n_fail++;
      $display("FAIL stray_start: got busy=%b rdy=%b acc=%h expected 1 1 4000", busy, in_ready, out_result);
    end
    in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h3C00;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h4200) begin
      n_fail++;
      $display("FAIL stray_cnt_kept: got vld=%b res=%h expected 1 4200", out_valid, out_result);
    end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    begin_job(8'd3, 16'h0000);
    in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h4000;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 16'h0000) begin
      n_fail++;
      $display("FAIL midjob_reset: got busy=%b rdy=%b vld=%b res=%h expected 0 0 0 0000", busy, in_ready, out_valid, out_result);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet%0d: got vld=%b rdy=%b expected 0 0", i, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    begin_job(8'd1, 16'h0000);
    in_valid = 1'b1; in_x = 16'h3C00; in_y = 16'h3C00;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h3C00) begin
      n_fail++;
      $display("FAIL fresh_job: got vld=%b res=%h expected 1 3c00", out_valid, out_result);
    end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_overflow();
    test_cancel();
    test_stray_start_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/f16_dot_seq.md
F16_DOT_SEQ -- requirements
Module: f16_dot_seq

Interface
REQ-001 Parameter LEN_W, default 8, width of the element-count field.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a dot-product job; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of x/y pairs in the job; sampled with start.
REQ-006 z_init  input  16  f16 accumulator seed; sampled with start.
REQ-007 in_valid  input  1  x/y pair present.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 in_x, in_y  input  16 each  f16 operands.
REQ-010 out_valid  output  1  job result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_result  output  16  f16 accumulated result.
REQ-013 out_ovf  output  1  sticky flag: some step saturated (exponent field 5'h1F).
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, and DONE.
REQ-016 In IDLE, start=1 with len!=0 SHALL do all of the following: load acc<=z_init, cnt<=len, and ovf<=0; then go to RUN.
REQ-017 In IDLE, start=1 with len=0 SHALL load acc<=z_init and ovf<=0, then go directly to DONE.
REQ-018 in_ready SHALL equal 1 exactly when the state is RUN.
REQ-019 A pair is accepted when in_valid and in_ready are both 1; on acceptance the block SHALL set acc<=fmac(in_x,in_y,acc), i.e. x*y+z with z=acc, and decrement cnt.
REQ-020 Computation timing: one pair per cycle, with the f16 multiply-add evaluated combinationally within the accepting cycle and no bubbles between back-to-back pairs.
REQ-021 On acceptance, if the fmac result exponent equals 5'h1F, ovf SHALL be set; once set, it stays set until the next job start.
REQ-022 When a pair is accepted with cnt=1, the next state SHALL be DONE, so out_valid rises one cycle after the last accept.
REQ-023 In RUN with in_valid=0, all state SHALL hold.
REQ-024 In DONE, out_valid=1, out_result=acc, and out_ovf=ovf; these SHALL stay stable until out_ready=1.
REQ-025 In DONE, out_ready=1 SHALL return the FSM to IDLE in the next cycle.
REQ-026 A start asserted while busy=1 SHALL be ignored; it is not queued.
REQ-027 A start in the same cycle as a DONE handshake SHALL be ignored; a new job needs start in IDLE.
REQ-028 Arithmetic follows the FMAC datapath rules:
  - a zero exponent on x or y is treated as zero product;
  - overflow saturates to {sign,5'h1F,10'h3FF};
  - underflow flushes to signed zero;
  - results are truncated, with no rounding.
REQ-029 cnt width SHALL be LEN_W; it never wraps, because decrement happens only while cnt>=1 in RUN.
REQ-030 out_result and out_ovf SHALL read as acc and ovf in all states; they are only meaningful while out_valid=1.

Reset
REQ-031 With rst_n=0 at a clock edge, the block SHALL set: state=IDLE, acc=16'h0000, cnt=0, ovf=0.
REQ-032 The resulting outputs SHALL be: in_ready=0, out_valid=0, busy=0, out_result=16'h0000, out_ovf=0.
REQ-033 Reset asserted mid-job (RUN or DONE) SHALL abandon the job without producing a result; the first post-reset cycle is IDLE.

Structure
REQ-034 The following SHALL live in shared package f16_pkg, for reuse by other f16 blocks:
  - FSM state encoding;
  - f16 field constants: BIAS=15, EXP_MAX=5'h1F, MAX_FINITE=16'h7BFF, saturated pattern 16'h7FFF (sign inserted).
REQ-035 Exactly one sub-module SHALL be instantiated: f16_fmac_normal_no_grs, the combinational f16 FMAC core, with x=in_x, y=in_y, z=acc.
REQ-036 The FSM, counter, accumulator, and ovf register SHALL be in f16_dot_seq; there SHALL be no other instances.

Verification
REQ-037 Basic dot product:
  - Stimulus: start, len=2, z_init=16'h0000; pairs (3C00,4000) then (4000,4000), sent back-to-back.
  - Response: out_valid in the cycle after the 2nd accept, out_result=16'h4600 (6.0), out_ovf=0.
REQ-038 Zero length:
  - Stimulus: start, len=0, z_init=16'h4200.
  - Response: out_valid one cycle later, out_result=16'h4200, in_ready never asserted.
REQ-039 Input and output backpressure:
  - Stimulus: len=3; in_valid toggled 1,0,0,1,0,1; out_ready held 0 for 5 cycles, then 1.
  - Response: exactly 3 accepts; result held stable over all 5 stall cycles; IDLE one cycle after out_ready.
REQ-040 Overflow:
  - Stimulus: len=1, z_init=0, pair (7BFF,7BFF).
  - Response: out_result=16'h7FFF, out_ovf=1; out_ovf=0 on the next job with pair (3C00,3C00), which gives 16'h3C00.
REQ-041 Cancellation and zero operand:
  - Stimulus: len=2, z_init=16'h4000 (2.0); pairs (BC00,4000) then (0000,5000).
  - Response: out_result=16'h0000.
REQ-042 Ignored start and reset mid-job:
  - Stimulus: start pulsed in RUN; then rst_n=0 for one cycle mid-RUN.
  - Response: the stray start does not alter cnt or acc; after reset busy=0, in_ready=0, and no out_valid until a fresh start.
